// File: rtl/heap_arbiter_if.sv
// Heap arbiter bus: requester-side handshake plus the single heap port.
// The arbiter uses the slave modport; requesters and the heap use master.
interface heap_arbiter_if #(
   parameter int NReq      = 3,
   parameter int AddrWidth = 12,
   parameter int DataWidth = 12
);
   logic [NReq-1:0]           req;
   logic [NReq-1:0]           lock;
   logic [NReq-1:0]           write;
   logic [NReq*AddrWidth-1:0] addr;
   logic [NReq*DataWidth-1:0] wdata;
   logic [NReq-1:0]           gnt;
   logic [NReq-1:0]           done;
   logic [DataWidth-1:0]      rdata;
   logic                      memWrite;
   logic [AddrWidth-1:0]      memAddress;
   logic [DataWidth-1:0]      memIn;
   logic [DataWidth-1:0]      memOut;

   modport master (
      output req, lock, write, addr, wdata, memOut,
      input  gnt, done, rdata, memWrite, memAddress, memIn
   );

   modport slave (
      input  req, lock, write, addr, wdata, memOut,
      output gnt, done, rdata, memWrite, memAddress, memIn
   );
endinterface

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing the single-port synchronous heap memory.
// One access per cycle, combinational grant, registered completion one
// cycle later. A granted requester holding lock keeps the port until its
// req drops or it deasserts lock on a granted cycle.
module heap_arbiter #(
   parameter int NReq      = 3,
   parameter int AddrWidth = 12,
   parameter int DataWidth = 12
) (
   input  logic          clock,
   input  logic          reset,
   heap_arbiter_if.slave bus
);
   localparam int PtrW = (NReq > 1) ? $clog2(NReq) : 1;

   logic [PtrW-1:0] ptr;
   logic [PtrW-1:0] owner;
   logic            locked;
   logic [NReq-1:0] doneReg;

   logic [NReq-1:0] gntVec;
   logic [PtrW-1:0] gntIdx;
   logic            gntAny;

   // Grant selection: locked owner first, else first requester from ptr upward
   always_comb begin
      int cand;
      gntVec = '0;
      gntIdx = '0;
      gntAny = 1'b0;
      cand   = 0;
      if (!reset) begin
         if (locked && bus.req[owner]) begin
            gntAny = 1'b1;
            gntIdx = owner;
         end else begin
            for (int k = 0; k < NReq; k++) begin
               cand = int'(ptr) + k;
               if (cand >= NReq) cand = cand - NReq;
               if (!gntAny && bus.req[PtrW'(cand)]) begin
                  gntAny = 1'b1;
                  gntIdx = PtrW'(cand);
               end
            end
         end
         if (gntAny) gntVec[gntIdx] = 1'b1;
      end
   end

   // Heap port mux: granted requester drives the port, idle drives zeros
   always_comb begin
      bus.memWrite   = 1'b0;
      bus.memAddress = '0;
      bus.memIn      = '0;
      for (int i = 0; i < NReq; i++) begin
         if (gntVec[i]) begin
            bus.memWrite   = bus.write[i];
            bus.memAddress = bus.addr[i*AddrWidth +: AddrWidth];
            bus.memIn      = bus.wdata[i*DataWidth +: DataWidth];
         end
      end
   end

   // Arbitration state: pointer advance, ownership/lock capture, completion
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr     <= '0;
         owner   <= '0;
         locked  <= 1'b0;
         doneReg <= '0;
      end else if (gntAny) begin
         doneReg <= gntVec;
         ptr     <= (gntIdx == PtrW'(NReq - 1)) ? '0 : gntIdx + 1'b1;
         owner   <= gntIdx;
         locked  <= bus.lock[gntIdx];
      end else begin
         doneReg <= '0;
         locked  <= 1'b0;
      end
   end

   assign bus.gnt   = gntVec;
   assign bus.done  = doneReg;
   assign bus.rdata = bus.memOut;
endmodule

// File: tb/tb_heap_arbiter.sv
// Bench for heap_arbiter: directed scenarios followed by random traffic,
// a behavioural heap, a reference model and a completion scoreboard.
module tb_heap_arbiter;
   localparam int N  = 3;
   localparam int AW = 12;
   localparam int DW = 12;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;

   heap_arbiter_if #(.NReq(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

   heap_arbiter #(.NReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural heap: registered output, echoes write data
   logic [DW-1:0] heap [1<<AW];
   always @(posedge clock) begin
      if (bus.memWrite) begin
         heap[bus.memAddress] <= bus.memIn;
         bus.memOut           <= bus.memIn;
      end else begin
         bus.memOut <= heap[bus.memAddress];
      end
   end

   function automatic logic [DW-1:0] initVal(input int a);
      return DW'((a * 37 + 5) & ((1 << DW) - 1));
   endfunction

   int nChecks = 0;
   int nPass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Requester stimulus state
   bit [N-1:0]    pReq, pLock, pWrite;
   logic [AW-1:0] pAddr  [N];
   logic [DW-1:0] pWdata [N];

   // Reference model state
   int            mPtr = 0, mOwner = 0;
   bit            mLocked = 0;
   logic [DW-1:0] modelMem [int];
   int            lastGnt;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      int            when;
   } exp_t;
   exp_t sb [$];

   function automatic logic [DW-1:0] memRead(input int a);
      if (modelMem.exists(a)) return modelMem[a];
      return initVal(a);
   endfunction

   function automatic int modelPick();
      if (mLocked && pReq[mOwner]) return mOwner;
      for (int k = 0; k < N; k++) begin
         int c = (mPtr + k) % N;
         if (pReq[c]) return c;
      end
      return -1;
   endfunction

   task automatic setAcc(input int i, input bit rq, input bit lk, input bit wr,
                         input int ad, input int wd);
      pReq[i]   = rq;
      pLock[i]  = lk;
      pWrite[i] = wr;
      pAddr[i]  = AW'(ad);
      pWdata[i] = DW'(wd);
   endtask

   // One clock cycle: drive, compare grant and heap port, advance model
   task automatic cycle(input bit rst);
      int            g;
      logic [N-1:0]  expG;
      logic [DW-1:0] d;
      @(posedge clock);
      #1;
      reset = rst;
      for (int i = 0; i < N; i++) begin
         bus.req[i]                 = pReq[i];
         bus.lock[i]                = pLock[i];
         bus.write[i]               = pWrite[i];
         bus.addr[i*AW +: AW]       = pAddr[i];
         bus.wdata[i*DW +: DW]      = pWdata[i];
      end
      #1;
      g    = rst ? -1 : modelPick();
      expG = (g >= 0) ? N'(1 << g) : '0;
      check("gnt", 64'(bus.gnt), 64'(expG));
      if (g >= 0)
         check("heap_port", 64'({bus.memWrite, bus.memAddress, bus.memIn}),
               64'({pWrite[g], pAddr[g], pWdata[g]}));
      else
         check("heap_idle", 64'({bus.memWrite, bus.memAddress, bus.memIn}), 64'(0));
      lastGnt = g;
      if (rst) begin
         mPtr    = 0;
         mOwner  = 0;
         mLocked = 0;
      end else if (g >= 0) begin
         if (pWrite[g]) begin
            d = pWdata[g];
            modelMem[int'(pAddr[g])] = pWdata[g];
         end else begin
            d = memRead(int'(pAddr[g]));
         end
         sb.push_back('{idx: g, data: d, when: cyc + 1});
         mPtr    = (g + 1) % N;
         mOwner  = g;
         mLocked = pLock[g];
      end else begin
         mLocked = 0;
      end
   endtask

   // Completion monitor: pops the scoreboard whenever done is presented
   always @(negedge clock) begin
      exp_t e;
      if (!$isunknown(bus.done) && bus.done != '0) begin
         if (sb.size() == 0) begin
            check("done_unexpected", 64'(bus.done), 64'(0));
         end else begin
            e = sb.pop_front();
            check("done_rdata", 64'({bus.done, bus.rdata}), 64'({N'(1 << e.idx), e.data}));
            check("done_cycle", 64'(cyc), 64'(e.when));
         end
      end else if (sb.size() > 0 && sb[0].when <= cyc) begin
         e = sb.pop_front();
         check("done_missing", 64'(bus.done), 64'(N'(1 << e.idx)));
      end
   end

   task automatic newAcc(input int i);
      setAcc(i, 1'b1, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 15), $urandom_range(0, (1 << DW) - 1));
   endtask

   int rr [6];

   initial begin
      for (int a = 0; a < (1 << AW); a++) heap[a] = initVal(a);
      bus.memOut = '0;
      pReq = '0; pLock = '0; pWrite = '0;
      for (int i = 0; i < N; i++) begin
         pAddr[i]  = '0;
         pWdata[i] = '0;
      end

      // Reset with everyone writing to address 0
      for (int i = 0; i < N; i++) setAcc(i, 1, 0, 1, 0, 12'hABC + i);
      repeat (3) cycle(1'b1);

      // Round-robin from reset, continuous reads
      for (int i = 0; i < N; i++) setAcc(i, 1, 0, 0, 20 + i, 0);
      for (int k = 0; k < 6; k++) begin
         cycle(1'b0);
         rr[k] = lastGnt;
      end
      for (int k = 0; k < 6; k++) check("rr_order", 64'(rr[k]), 64'(k % 3));

      // Address 0 untouched by the accesses presented during reset
      pReq = '0;
      setAcc(0, 1, 0, 0, 0, 0);
      cycle(1'b0);
      pReq = '0;

      // Single write then read by requester 1
      setAcc(1, 1, 0, 1, 5, 33);
      cycle(1'b0);
      check("wr_gnt", 64'(lastGnt), 64'(1));
      setAcc(1, 1, 0, 0, 5, 0);
      cycle(1'b0);
      check("rd_gnt", 64'(lastGnt), 64'(1));
      pReq = '0;
      cycle(1'b0);

      // Locked burst by requester 2 while 0 and 1 wait
      setAcc(0, 1, 0, 0, 30, 0);
      setAcc(1, 1, 0, 0, 31, 0);
      for (int k = 0; k < 4; k++) begin
         setAcc(2, 1, 1, 1, k, 11 * (k + 1));
         cycle(1'b0);
         check("lock_gnt", 64'(lastGnt), 64'(2));
      end
      pReq[2] = 1'b0;
      cycle(1'b0);
      check("unlock_gnt", 64'(lastGnt), 64'(0));
      pReq[0] = 1'b0;
      cycle(1'b0);
      pReq = '0;

      // Idle gap, then a lone requester
      repeat (3) begin
         cycle(1'b0);
         check("idle_gnt", 64'(lastGnt), 64'(-1));
      end
      setAcc(1, 1, 0, 0, 2, 0);
      cycle(1'b0);
      check("lone_gnt", 64'(lastGnt), 64'(1));
      pReq = '0;

      // Reset in the middle of a locked burst
      setAcc(2, 1, 1, 1, 8, 100);
      cycle(1'b0);
      setAcc(2, 1, 1, 1, 9, 200);
      cycle(1'b1);
      setAcc(0, 1, 0, 0, 8, 0);
      setAcc(1, 1, 0, 0, 9, 0);
      setAcc(2, 1, 0, 0, 9, 0);
      cycle(1'b0);
      check("post_reset_gnt", 64'(lastGnt), 64'(0));
      pReq[0] = 1'b0;
      cycle(1'b0);
      pReq[1] = 1'b0;
      cycle(1'b0);
      pReq = '0;
      cycle(1'b0);

      // Random traffic with occasional locks and resets
      for (int n = 0; n < 600; n++) begin
         cycle($urandom_range(0, 99) == 0);
         for (int i = 0; i < N; i++) begin
            if (lastGnt == i) begin
               if (pLock[i] && $urandom_range(0, 3) != 0) begin
                  newAcc(i);
                  pLock[i] = 1'b1;
               end else if ($urandom_range(0, 2) == 0) begin
                  newAcc(i);
               end else begin
                  pReq[i] = 1'b0;
               end
            end else if (!pReq[i] && $urandom_range(0, 2) == 0) begin
               newAcc(i);
            end
         end
      end

      // Drain outstanding completions
      pReq = '0;
      repeat (3) cycle(1'b0);
      check("scoreboard_empty", 64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule

// File: doc/heap_arbiter.md
# heap_arbiter

Round-robin arbiter that shares the single-port, synchronous `heapMemory` between several requesters of the test-program engine: the instruction executor, the array-shift sequencer and the debug dump port. It grants at most one requester per cycle and drives the heap port from that requester. It returns completion and read data one cycle later. A lock input lets a requester keep the port for multi-access sequences, such as array shifts, without interleaving.

## Interface
- `NReq`, 3, number of requesters (2..8)
- `AddrWidth`, 12, heap address width
- `DataWidth`, 12, heap element width; matches `MemoryElementWidth`
- `clock`  in  1  clock; the heap memory is clocked by the same clock
- `reset`  in  1  reset, synchronous, active-high
- `req`  in  NReq  request per requester; held until granted
- `lock`  in  NReq  requester keeps ownership after its grant while `lock` and `req` stay high
- `write`  in  NReq  1 = write, 0 = read, per requester
- `addr`  in  NReq*AddrWidth  packed addresses; requester i at [i*AddrWidth +: AddrWidth]
- `wdata`  in  NReq*DataWidth  packed write data, same packing
- `gnt`  out  NReq  one-hot grant, combinational, same cycle as issue
- `done`  out  NReq  one-hot completion, registered, one cycle after grant
- `rdata`  out  DataWidth  heap output, valid while any `done` bit is high
- `memWrite`  out  1  heap write enable
- `memAddress`  out  AddrWidth  heap address
- `memIn`  out  DataWidth  heap write data
- `memOut`  in  DataWidth  heap read data, registered inside the heap

## Operation
- State: round-robin pointer `ptr` (0..NReq-1), `owner` index plus `locked` flag, registered `done` vector.
- **Grant selection.** This is combinational.
  - If `locked` and `req[owner]` are high, grant `owner`.
  - Otherwise grant the first i with `req[i]` high, searching from `ptr` upward with wrap modulo NReq.
  - At most one `gnt` bit is high. With no request, `gnt` = 0.
- **Heap port drive.**
  - When `gnt[i]` is high: `memWrite = write[i]`, `memAddress = addr[i]`, `memIn = wdata[i]`.
  - When idle: `memWrite` = 0, `memAddress` = 0, `memIn` = 0. An idle cycle never writes.
- **On the clock edge with `gnt[i]` high:**
  - `done <= 1 << i`.
  - `ptr <= (i+1) mod NReq`.
  - `owner <= i`.
  - `locked <= lock[i]`.
- **On the clock edge with no grant:** `done <= 0`, `locked <= 0`, `ptr` unchanged.
- **Lock release.** If `locked` is high but `req[owner]` has dropped, lock is released. Normal round-robin applies in that same cycle.
- `rdata = memOut`.
  - Read completion: `rdata` is the stored word.
  - Write completion: `rdata` is the written data, since the heap echoes `in`.
- **Back-to-back.** A requester may present a new access in the cycle its `done` is high. It is eligible normally and is granted again only if it is locked or no other requester is pending.
- **Width rules.** No arithmetic on data. Addresses are passed unmodified; the heap handles range.

## Timing
- **Reset values:**
  - `gnt` = 0 (while `reset` is high, regardless of `req`)
  - `done` = 0
  - `memWrite` = 0, `memAddress` = 0, `memIn` = 0
  - `ptr` = 0, `locked` = 0
- **Reset mid-operation.** An access granted in the reset cycle is not issued (`memWrite` forced 0). No `done` follows reset.
- **Latency:**
  - Request to grant: 0 cycles if selected.
  - Grant to `done`/`rdata`: 1 cycle.
  - Throughput: 1 access per cycle.
- **Requester contract.** `req`, `write`, `addr` and `wdata` are stable from assertion until the cycle `gnt` is high. The requester deasserts `req` or changes the access after its grant edge.
- **Fairness.** With all requesters continuously requesting and none locked, each is granted once every NReq cycles.
- **Lock fairness.** A locked owner may starve others indefinitely; this is intended. Lock is cleared when its `req` drops for one cycle.
- **Simultaneous events.** A locked owner's new `lock` value is sampled on each of its grants. `lock` going low on a granted cycle releases ownership at that edge.

## Test plan
- **Reset behaviour.** Assert `reset` with `req` = 3'b111, `write` = 1 → `gnt` = 0, `memWrite` = 0, no `done` the next cycle. Heap contents at addr 0 are unchanged.
- **Single write then read.**
  - Requester 1 writes 33 to addr 5 → `gnt` = 3'b010; next cycle `done` = 3'b010, `rdata` = 33.
  - Requester 1 then reads addr 5 → `done` = 3'b010, `rdata` = 33.
- **Round-robin.** All three request reads continuously from reset → grants 0,1,2,0,1,2. Each `done` follows its grant by one cycle.
- **Lock burst.** Requester 2 asserts `lock` with 4 consecutive writes (addr 0..3 = 11,22,33,44) while 0 and 1 request → `gnt` = 3'b100 for 4 cycles. After `req[2]` drops, requester 0 is granted next (`ptr` = 0).
- **Idle gap.** No requests for 3 cycles → `memWrite` = 0, `done` = 0, `ptr` unchanged. Then requester 1 alone is granted immediately.
- **Reset mid-burst.** Assert reset during a locked burst at its 2nd write → `locked` = 0, `done` = 0. Heap holds only the first write; after reset, requester 0 wins when all request.
